dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single-ported data memory.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate; otherwise the CPU always wins.
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | arbitrate; only state in which req inputs are sampled
  // ISSUE | one-cycle memory access for the latched winner, gnt high
  // WAIT  | read only: MEM_LAT-1 cycles of memory latency (down-counter)
  // RESP  | read data captured from memory; rvalid follows on the next cycle
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] LAT_LOAD = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $error("dmem_arbiter: MEM_LAT must be in 1..4");
    end
  endgenerate

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic              r_owner_dbg;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_gnt;
  logic              r_dbg_gnt;
  logic              r_cpu_rvalid;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              w_pick_dbg;

`ifdef ARB_ROUND_ROBIN_EN
  // Reset value DBG so the CPU takes the first tie.
  logic r_last_dbg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_last_dbg <= 1'b1;
    else if (r_state == S_ISSUE)
      r_last_dbg <= r_owner_dbg;
  end

  assign w_pick_dbg = dbg_req & (~cpu_req | ~r_last_dbg);
`else
  assign w_pick_dbg = dbg_req & ~cpu_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_owner_dbg  <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req || dbg_req) begin
            r_owner_dbg <= w_pick_dbg;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_pick_dbg ? dbg_we    : cpu_we;
            r_mem_addr  <= w_pick_dbg ? dbg_addr  : cpu_addr;
            r_mem_wdata <= w_pick_dbg ? dbg_wdata : cpu_wdata;
            r_cpu_gnt   <= ~w_pick_dbg;
            r_dbg_gnt   <= w_pick_dbg;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_en  <= 1'b0;
          r_mem_we  <= 1'b0;
          r_cpu_gnt <= 1'b0;
          r_dbg_gnt <= 1'b0;
          if (r_mem_we) begin
            r_state <= S_IDLE;
          end else if (MEM_LAT == 1) begin
            r_state <= S_RESP;
          end else begin
            r_cnt   <= LAT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0)
            r_state <= S_RESP;
          else
            r_cnt <= r_cnt - 2'd1;
        end
        S_RESP: begin
          // Memory data is valid in this cycle (ISSUE + MEM_LAT).
          r_rdata      <= mem_rdata;
          r_cpu_rvalid <= ~r_owner_dbg;
          r_dbg_rvalid <= r_owner_dbg;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign dbg_gnt    = r_dbg_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;
  assign cpu_rdata  = r_rdata;
  assign dbg_rdata  = r_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = (r_state != S_IDLE);

endmodule
